// File: rtl/vga_mode_detect.sv
// vga_mode_detect: measures AD9980 HSYNC/VSYNC timing in the Clk domain and
// classifies the incoming video mode (VGA/SVGA/XGA) for the I2C init block.
//
// Ports:
//   Clk                           system clock
//   Reset                         asynchronous, active-high reset
//   Hsync_in                      AD9980 HSYNC, asynchronous, any polarity
//   Vsync_in                      AD9980 VSYNC, asynchronous, any polarity
//   Mode[1:0]                     0=none, 1=VGA(525), 2=SVGA(628), 3=XGA(806)
//   Mode_valid                    high while locked
//   Pixel_clk_greater_than_65Mhz  high iff Mode==3
//   Mode_change                   1-cycle pulse on every entry to lock
//   Line_count[10:0]              HSYNC edges in last complete frame
//   Hs_period[15:0]               Clk cycles between last two HSYNC edges
module vga_mode_detect #(
    parameter int CLK_RATE_MHZ  = 200,
    parameter int HS_TIMEOUT    = 20000,
    parameter int MAX_LINES     = 1023,
    parameter int LINE_TOL      = 2,
    parameter int STABLE_FRAMES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Hsync_in,
    input  logic        Vsync_in,
    output logic [1:0]  Mode,
    output logic        Mode_valid,
    output logic        Pixel_clk_greater_than_65Mhz,
    output logic        Mode_change,
    output logic [10:0] Line_count,
    output logic [15:0] Hs_period
);

    if (CLK_RATE_MHZ < 1 || HS_TIMEOUT < 1 || HS_TIMEOUT > 65535 ||
        STABLE_FRAMES < 1 || STABLE_FRAMES > 255) begin : g_bad_param
        $error("vga_mode_detect: parameter out of range");
    end

    localparam int MAXL_C = (MAX_LINES > 2047) ? 2047 : MAX_LINES;

    localparam logic [15:0] TO_VAL = 16'(HS_TIMEOUT);
    localparam logic [10:0] MAXL   = 11'(MAXL_C);
    localparam logic [7:0]  SF_M1  = 8'(STABLE_FRAMES - 1);

    typedef enum logic [1:0] {
        S_NO_SIGNAL,
        S_ACQUIRE,
        S_LOCKED
    } state_t;

    // bit0/bit1 synchronize, bit2 holds the previous synchronized level
    logic [2:0]  r_hs_sync;
    logic [2:0]  r_vs_sync;
    logic        r_hs_edge;
    logic        r_vs_edge;

    logic [15:0] r_hs_cnt;
    logic [15:0] r_hs_period;
    logic [10:0] r_line_cnt;
    logic [10:0] r_line_count;

    state_t      r_state;
    logic [1:0]  r_mode;
    logic [1:0]  r_prev;
    logic [7:0]  r_stable;
    logic [7:0]  r_mism;
    logic        r_valid;
    logic        r_hi;
    logic        r_chg;

    state_t      w_state_nxt;
    logic [1:0]  w_mode_nxt;
    logic [1:0]  w_prev_nxt;
    logic [7:0]  w_stable_nxt;
    logic [7:0]  w_mism_nxt;
    logic        w_chg_nxt;

    logic [10:0] w_captured;
    logic [1:0]  w_class;
    logic        w_match;
    logic [7:0]  w_stable_inc;
    logic        w_loss;

    function automatic logic near(input logic [10:0] n, input int c);
        return (int'(n) >= c - LINE_TOL) && (int'(n) <= c + LINE_TOL);
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hs_sync <= '0;
            r_vs_sync <= '0;
            r_hs_edge <= 1'b0;
            r_vs_edge <= 1'b0;
        end else begin
            r_hs_sync <= {r_hs_sync[1:0], Hsync_in};
            r_vs_sync <= {r_vs_sync[1:0], Vsync_in};
            r_hs_edge <= r_hs_sync[1] & ~r_hs_sync[2];
            r_vs_edge <= r_vs_sync[1] & ~r_vs_sync[2];
        end
    end

    // An HS edge coincident with VS closes the ending frame
    always_comb begin
        w_captured = r_line_cnt;
        if (r_hs_edge && r_line_cnt != 11'h7FF) begin
            w_captured = r_line_cnt + 11'd1;
        end
    end

    // The reported period counts the edge cycle itself, so a
    // pulse train with N-cycle spacing reads back as N
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hs_cnt    <= '0;
            r_hs_period <= '0;
        end else if (r_hs_edge) begin
            r_hs_cnt    <= '0;
            r_hs_period <= (r_hs_cnt == 16'hFFFF) ? 16'hFFFF
                                                  : r_hs_cnt + 16'd1;
        end else if (r_hs_cnt != 16'hFFFF) begin
            r_hs_cnt <= r_hs_cnt + 16'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_line_cnt   <= '0;
            r_line_count <= '0;
        end else if (r_vs_edge) begin
            r_line_cnt   <= '0;
            r_line_count <= w_captured;
        end else if (r_hs_edge && r_line_cnt != 11'h7FF) begin
            r_line_cnt <= r_line_cnt + 11'd1;
        end
    end

    always_comb begin
        w_class = 2'd0;
        if (near(w_captured, 525)) begin
            w_class = 2'd1;
        end else if (near(w_captured, 628)) begin
            w_class = 2'd2;
        end else if (near(w_captured, 806)) begin
            w_class = 2'd3;
        end
    end

    assign w_loss = (r_hs_cnt == TO_VAL) || (r_line_cnt > MAXL);

    assign w_match      = (w_class != 2'd0) && (w_class == r_prev);
    assign w_stable_inc = w_match ? r_stable + 8'd1 : 8'd0;

    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_prev_nxt   = r_prev;
        w_stable_nxt = r_stable;
        w_mism_nxt   = r_mism;
        w_chg_nxt    = 1'b0;
        if (w_loss) begin
            w_state_nxt  = S_NO_SIGNAL;
            w_mode_nxt   = 2'd0;
            w_prev_nxt   = 2'd0;
            w_stable_nxt = '0;
            w_mism_nxt   = '0;
        end else begin
            unique case (r_state)
                S_NO_SIGNAL: begin
                    w_mode_nxt = 2'd0;
                    // first VS only opens a frame; prev is cleared so
                    // lock always needs a full run of fresh frames
                    if (r_vs_edge) begin
                        w_state_nxt  = S_ACQUIRE;
                        w_prev_nxt   = 2'd0;
                        w_stable_nxt = '0;
                        w_mism_nxt   = '0;
                    end
                end
                S_ACQUIRE: begin
                    if (r_vs_edge) begin
                        w_prev_nxt = w_class;
                        if (w_class != 2'd0 && w_stable_inc == SF_M1) begin
                            w_state_nxt  = S_LOCKED;
                            w_mode_nxt   = w_class;
                            w_chg_nxt    = 1'b1;
                            w_stable_nxt = '0;
                            w_mism_nxt   = '0;
                        end else begin
                            w_stable_nxt = w_stable_inc;
                        end
                    end
                end
                S_LOCKED: begin
                    if (r_vs_edge) begin
                        if (w_class == r_mode) begin
                            w_mism_nxt = '0;
                        end else if (r_mism == SF_M1) begin
                            w_state_nxt  = S_ACQUIRE;
                            w_mode_nxt   = 2'd0;
                            w_prev_nxt   = 2'd0;
                            w_stable_nxt = '0;
                            w_mism_nxt   = '0;
                        end else begin
                            w_mism_nxt = r_mism + 8'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_NO_SIGNAL;
                    w_mode_nxt  = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_NO_SIGNAL;
            r_mode   <= 2'd0;
            r_prev   <= 2'd0;
            r_stable <= '0;
            r_mism   <= '0;
            r_valid  <= 1'b0;
            r_hi     <= 1'b0;
            r_chg    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode   <= w_mode_nxt;
            r_prev   <= w_prev_nxt;
            r_stable <= w_stable_nxt;
            r_mism   <= w_mism_nxt;
            r_valid  <= (w_state_nxt == S_LOCKED);
            r_hi     <= (w_mode_nxt == 2'd3);
            r_chg    <= w_chg_nxt;
        end
    end

    assign Mode                         = r_mode;
    assign Mode_valid                   = r_valid;
    assign Pixel_clk_greater_than_65Mhz = r_hi;
    assign Mode_change                  = r_chg;
    assign Line_count                   = r_line_count;
    assign Hs_period                    = r_hs_period;

endmodule

// File: tb/tb_vga_mode_detect.sv
// tb_vga_mode_detect: frame-level stimulus with a scoreboard of expected
// mode outputs, checked a fixed latency after each VSYNC rise.
module tb_vga_mode_detect;

    localparam int TO = 200;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Hsync_in;
    logic        Vsync_in;
    logic [1:0]  Mode;
    logic        Mode_valid;
    logic        Pixel_clk_greater_than_65Mhz;
    logic        Mode_change;
    logic [10:0] Line_count;
    logic [15:0] Hs_period;

    always #5 Clk = ~Clk;

    vga_mode_detect #(
        .HS_TIMEOUT (TO)
    ) dut (
        .Clk                          (Clk),
        .Reset                        (Reset),
        .Hsync_in                     (Hsync_in),
        .Vsync_in                     (Vsync_in),
        .Mode                         (Mode),
        .Mode_valid                   (Mode_valid),
        .Pixel_clk_greater_than_65Mhz (Pixel_clk_greater_than_65Mhz),
        .Mode_change                  (Mode_change),
        .Line_count                   (Line_count),
        .Hs_period                    (Hs_period)
    );

    typedef struct {
        int id;
        int mode;
        int valid;
        int hi;
        int pulses;
        int lc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cd = 0;
    int   pulse_cnt = 0;
    int   fid = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // one clock; outputs sampled 1 time unit after the edge
    task automatic tick();
        exp_t e;
        @(posedge Clk);
        #1;
        if (Mode_change) pulse_cnt++;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("f%0d.mode", e.id), Mode, e.mode);
                    chk($sformatf("f%0d.valid", e.id), Mode_valid, e.valid);
                    chk($sformatf("f%0d.hi", e.id),
                        Pixel_clk_greater_than_65Mhz, e.hi);
                    chk($sformatf("f%0d.lines", e.id), Line_count, e.lc);
                    chk($sformatf("f%0d.pulses", e.id), pulse_cnt, e.pulses);
                    pulse_cnt = 0;
                end
            end
        end
    endtask

    task automatic push(input int m, input int v, input int h,
                        input int p, input int lc);
        fid++;
        sb.push_back('{fid, m, v, h, p, lc});
        // pin->sync(2)->edge reg->output reg
        cd = 4;
    endtask

    task automatic line();
        Hsync_in = 1'b1;
        tick();
        tick();
        Hsync_in = 1'b0;
        tick();
    endtask

    // n HS pulses then a VS rise; with simul the VS rises on the nth pulse
    task automatic frame(input int n, input bit simul,
                         input int m, input int v, input int h,
                         input int p, input int lc);
        for (int i = 0; i < n; i++) begin
            Hsync_in = 1'b1;
            if (simul && i == n - 1) begin
                Vsync_in = 1'b1;
                push(m, v, h, p, lc);
            end
            tick();
            tick();
            Hsync_in = 1'b0;
            tick();
        end
        if (!simul) begin
            Vsync_in = 1'b1;
            push(m, v, h, p, lc);
            tick();
        end
        tick();
        tick();
        Vsync_in = 1'b0;
        tick();
    endtask

    initial begin
        Reset    = 1'b1;
        Hsync_in = 1'b0;
        Vsync_in = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst.mode", Mode, 0);
        chk("rst.valid", Mode_valid, 0);
        chk("rst.hi", Pixel_clk_greater_than_65Mhz, 0);
        chk("rst.chg", Mode_change, 0);
        chk("rst.lines", Line_count, 0);
        chk("rst.hsper", Hs_period, 0);
        Reset = 1'b0;
        tick();

        // into ACQUIRE, then reset part way through a frame
        frame(100, 1'b0, 0, 0, 0, 0, 100);
        frame(525, 1'b0, 0, 0, 0, 0, 525);
        repeat (200) line();
        chk("pre.hsper", Hs_period, 3);
        Reset = 1'b1;
        #1;
        chk("arst.mode", Mode, 0);
        chk("arst.valid", Mode_valid, 0);
        chk("arst.chg", Mode_change, 0);
        chk("arst.lines", Line_count, 0);
        chk("arst.hsper", Hs_period, 0);
        repeat (3) tick();
        Reset = 1'b0;
        tick();

        // VGA relock: 5th VS edge locks; the 5th coincides with an HS
        frame(50, 1'b0, 0, 0, 0, 0, 50);
        repeat (3) frame(525, 1'b0, 0, 0, 0, 0, 525);
        frame(525, 1'b1, 1, 1, 0, 1, 525);
        frame(525, 1'b0, 1, 1, 0, 0, 525);

        // VGA -> SVGA: 3 tolerated mismatches, drop at 4th, lock 4 later
        repeat (3) frame(628, 1'b0, 1, 1, 0, 0, 628);
        frame(628, 1'b0, 0, 0, 0, 0, 628);
        repeat (3) frame(628, 1'b0, 0, 0, 0, 0, 628);
        frame(628, 1'b0, 2, 1, 0, 1, 628);

        // single glitch frame is ignored
        frame(600, 1'b0, 2, 1, 0, 0, 600);
        frame(628, 1'b0, 2, 1, 0, 0, 628);

        // two HS pulses 150 apart, then HSYNC stops
        Hsync_in = 1'b1;
        repeat (2) tick();
        Hsync_in = 1'b0;
        repeat (148) tick();
        Hsync_in = 1'b1;
        for (int k = 1; k <= TO + 5; k++) begin
            tick();
            if (k == 2) Hsync_in = 1'b0;
            if (k == 6) chk("hsper150", Hs_period, 150);
            if (k == TO + 4) chk("to.valid_hold", Mode_valid, 1);
            if (k == TO + 5) begin
                chk("to.valid", Mode_valid, 0);
                chk("to.mode", Mode, 0);
                chk("to.lines_kept", Line_count, 628);
                chk("to.hsper_kept", Hs_period, 150);
            end
        end

        // from NO_SIGNAL: 2 lines already counted before the loss
        frame(10, 1'b0, 0, 0, 0, 0, 12);
        frame(809, 1'b0, 0, 0, 0, 0, 809);
        frame(806, 1'b0, 0, 0, 0, 0, 806);
        frame(808, 1'b0, 0, 0, 0, 0, 808);
        frame(806, 1'b0, 0, 0, 0, 0, 806);
        frame(805, 1'b0, 3, 1, 1, 1, 805);

        // VSYNC stuck: lost once the line counter passes 1023
        repeat (1023) line();
        repeat (3) tick();
        chk("vs.valid_hold", Mode_valid, 1);
        chk("vs.mode_hold", Mode, 3);
        line();
        repeat (3) tick();
        chk("vs.valid", Mode_valid, 0);
        chk("vs.mode", Mode, 0);
        chk("vs.hi", Pixel_clk_greater_than_65Mhz, 0);
        chk("vs.lines_kept", Line_count, 805);
        repeat (4) tick();
        chk("loss.pulses", pulse_cnt, 0);
        chk("sb_left", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
